// File: rtl/mem_access_if.sv
// Load/store request, response and block-RAM port bundle for mem_access_unit.
// The slave side is the unit; the master side is the CPU datapath plus the RAM.
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for a word-addressed block RAM with
// byte-lane write enables and RD_LATENCY-cycle read data.
module mem_access_unit #(
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t      r_state;
    logic        r_we;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [1:0]  r_cnt;

    logic        w_accept;
    logic        w_err;
    logic [3:0]  w_we;
    logic [31:0] w_din;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_accept = bus.req_valid & bus.req_ready;

    always_comb begin
        w_err = 1'b0;
        w_we  = 4'b1111;
        w_din = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                w_we  = 4'b0001 << bus.req_addr[1:0];
                w_din = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_err = bus.req_addr[0];
                w_we  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_din = {2{bus.req_wdata[15:0]}};
            end
            2'b10:   w_err = (bus.req_addr[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
    end

    // Lane extraction uses the address bits latched at accept, not the live inputs.
    always_comb begin
        w_byte = bus.mem_dout[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
        case (r_size)
            2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
            default: w_ext = bus.mem_dout;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_we           <= 1'b0;
            r_signed       <= 1'b0;
            r_size         <= 2'b00;
            r_lane         <= 2'b00;
            r_cnt          <= 2'b00;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 4'b0000;
            bus.mem_addr   <= 32'h0;
            bus.mem_din    <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we          <= bus.req_we;
                        r_signed      <= bus.req_signed;
                        r_size        <= bus.req_size;
                        r_lane        <= bus.req_addr[1:0];
                        bus.req_ready <= 1'b0;
                        if (w_err) begin
                            r_state        <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= 32'h0;
                        end else begin
                            r_state      <= ACCESS;
                            bus.mem_en   <= 1'b1;
                            bus.mem_addr <= {2'b00, bus.req_addr[31:2]};
                            bus.mem_we   <= bus.req_we ? w_we : 4'b0000;
                            if (bus.req_we)
                                bus.mem_din <= w_din;
                        end
                    end
                end
                ACCESS: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 4'b0000;
                    r_cnt      <= 2'b00;
                    if (r_we) begin
                        r_state        <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= 32'h0;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 2'(RD_LATENCY - 1)) begin
                        r_state        <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= w_ext;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= 32'h0;
                    bus.req_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: two units (read latency 1 and 2) sharing one RAM model,
// expected responses queued at issue time and popped when the response appears.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_if m1();
    mem_access_if m2();

    mem_access_unit #(.RD_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(m1.slave));
    mem_access_unit #(.RD_LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(m2.slave));

    // Shared RAM: unit 1 writes and reads with one-cycle latency, unit 2 reads with two.
    logic [31:0] ram [0:63];
    logic [31:0] rd1, rd2a, rd2b;
    always @(posedge clk) begin
        if (m1.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (m1.mem_we[b]) ram[m1.mem_addr[5:0]][8*b +: 8] <= m1.mem_din[8*b +: 8];
            rd1 <= ram[m1.mem_addr[5:0]];
        end
        if (m2.mem_en) rd2a <= ram[m2.mem_addr[5:0]];
        rd2b <= rd2a;
    end
    assign m1.mem_dout = rd1;
    assign m2.mem_dout = rd2b;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic drive(input bit sel, input bit v, input bit we, input logic [1:0] sz,
                         input bit sg, input logic [31:0] a, input logic [31:0] wd);
        if (!sel) begin
            m1.req_valid = v; m1.req_we = we; m1.req_size = sz;
            m1.req_signed = sg; m1.req_addr = a; m1.req_wdata = wd;
        end else begin
            m2.req_valid = v; m2.req_we = we; m2.req_size = sz;
            m2.req_signed = sg; m2.req_addr = a; m2.req_wdata = wd;
        end
    endtask

    // Presents a request and returns #1 after the accept edge.
    task automatic issue(input bit sel, input bit we, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
        int n = 0;
        drive(sel, 1'b1, we, sz, sg, a, wd);
        while (!(sel ? m2.req_ready : m1.req_ready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        if (!hold) begin
            if (!sel) m1.req_valid = 1'b0; else m2.req_valid = 1'b0;
        end
    endtask

    // Latency counts the accept cycle as 1; 99 means no response within the bound.
    task automatic wait_resp(input bit sel, output bit err, output logic [31:0] rdata,
                             output int lat, output bit saw_en);
        lat = 1; saw_en = 0; err = 0; rdata = 32'hx;
        forever begin
            saw_en |= sel ? m2.mem_en : m1.mem_en;
            if (sel ? m2.resp_valid : m1.resp_valid) begin
                err   = sel ? m2.resp_err : m1.resp_err;
                rdata = sel ? m2.resp_rdata : m1.resp_rdata;
                return;
            end
            if (lat >= 20) begin
                lat = 99;
                return;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Issue one request, wait for its response and compare against the queued expectation.
    task automatic run_op(input string nm, input bit sel, input bit we, input logic [1:0] sz,
                          input bit sg, input logic [31:0] a, input logic [31:0] wd,
                          input bit exp_err, input logic [31:0] exp_rd, input int exp_lat);
        bit e, en; logic [31:0] rd; int lat; exp_t x;
        sb.push_back('{exp_err, exp_rd, exp_lat});
        issue(sel, we, sz, sg, a, wd, 1'b0);
        wait_resp(sel, e, rd, lat, en);
        x = sb.pop_front();
        n_chk++; if (lat !== x.lat) $display("FAIL %s latency got %0d want %0d", nm, lat, x.lat); else n_pass++;
        n_chk++; if (e !== x.err) $display("FAIL %s err got %0b want %0b", nm, e, x.err); else n_pass++;
        n_chk++; if (rd !== x.rdata) $display("FAIL %s rdata got %h want %h", nm, rd, x.rdata); else n_pass++;
        if (exp_err) begin
            n_chk++; if (en !== 1'b0) $display("FAIL %s mem_en asserted on error", nm); else n_pass++;
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (m1.req_ready !== 1'b1) $display("FAIL rst req_ready got %b want 1", m1.req_ready); else n_pass++;
        n_chk++; if (m1.resp_valid !== 1'b0) $display("FAIL rst resp_valid got %b want 0", m1.resp_valid); else n_pass++;
        n_chk++; if (m1.resp_err !== 1'b0) $display("FAIL rst resp_err got %b want 0", m1.resp_err); else n_pass++;
        n_chk++; if (m1.resp_rdata !== 32'h0) $display("FAIL rst resp_rdata got %h want 0", m1.resp_rdata); else n_pass++;
        n_chk++; if (m1.mem_en !== 1'b0) $display("FAIL rst mem_en got %b want 0", m1.mem_en); else n_pass++;
        n_chk++; if (m1.mem_we !== 4'b0) $display("FAIL rst mem_we got %b want 0", m1.mem_we); else n_pass++;
        n_chk++; if (m1.mem_addr !== 32'h0) $display("FAIL rst mem_addr got %h want 0", m1.mem_addr); else n_pass++;
        n_chk++; if (m1.mem_din !== 32'h0) $display("FAIL rst mem_din got %h want 0", m1.mem_din); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_word_store();
        bit e, en; logic [31:0] rd; int lat; exp_t x;
        sb.push_back('{1'b0, 32'h0, 2});
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        n_chk++; if (m1.mem_en !== 1'b1) $display("FAIL wst mem_en got %b want 1", m1.mem_en); else n_pass++;
        n_chk++; if (m1.mem_we !== 4'b1111) $display("FAIL wst mem_we got %b want 1111", m1.mem_we); else n_pass++;
        n_chk++; if (m1.mem_addr !== 32'h4) $display("FAIL wst mem_addr got %h want 4", m1.mem_addr); else n_pass++;
        n_chk++; if (m1.mem_din !== 32'hDEADBEEF) $display("FAIL wst mem_din got %h want deadbeef", m1.mem_din); else n_pass++;
        n_chk++; if (m1.req_ready !== 1'b0) $display("FAIL wst req_ready got %b want 0", m1.req_ready); else n_pass++;
        wait_resp(1'b0, e, rd, lat, en);
        x = sb.pop_front();
        n_chk++; if (lat !== x.lat) $display("FAIL wst latency got %0d want %0d", lat, x.lat); else n_pass++;
        n_chk++; if (e !== x.err || rd !== x.rdata) $display("FAIL wst resp got err=%b rd=%h want err=%b rd=%h", e, rd, x.err, x.rdata); else n_pass++;
        n_chk++; if (m1.mem_en !== 1'b0 || m1.mem_we !== 4'b0) $display("FAIL wst idle mem got en=%b we=%b want 0/0", m1.mem_en, m1.mem_we); else n_pass++;
        n_chk++; if (m1.mem_addr !== 32'h4) $display("FAIL wst held mem_addr got %h want 4", m1.mem_addr); else n_pass++;
    endtask

    task automatic test_byte_half_store();
        logic [3:0]  exp_we  [2] = '{4'b1000, 4'b1100};
        logic [31:0] exp_din [2] = '{32'hA5A5A5A5, 32'h12341234};
        logic [31:0] exp_adr [2] = '{32'h4, 32'h5};
        logic [1:0]  sz      [2] = '{2'b00, 2'b01};
        logic [31:0] adr     [2] = '{32'h13, 32'h16};
        logic [31:0] wd      [2] = '{32'hFFFFFFA5, 32'hABCD1234};
        bit e, en; logic [31:0] rd; int lat; exp_t x;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{1'b0, 32'h0, 2});
            issue(1'b0, 1'b1, sz[i], 1'b0, adr[i], wd[i], 1'b0);
            n_chk++; if (m1.mem_we !== exp_we[i]) $display("FAIL bhst%0d mem_we got %b want %b", i, m1.mem_we, exp_we[i]); else n_pass++;
            n_chk++; if (m1.mem_din !== exp_din[i]) $display("FAIL bhst%0d mem_din got %h want %h", i, m1.mem_din, exp_din[i]); else n_pass++;
            n_chk++; if (m1.mem_addr !== exp_adr[i]) $display("FAIL bhst%0d mem_addr got %h want %h", i, m1.mem_addr, exp_adr[i]); else n_pass++;
            wait_resp(1'b0, e, rd, lat, en);
            x = sb.pop_front();
            n_chk++; if (lat !== x.lat || e !== x.err || rd !== x.rdata) $display("FAIL bhst%0d resp got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h", i, lat, e, rd, x.lat, x.err, x.rdata); else n_pass++;
        end
    endtask

    task automatic test_loads_lat1();
        run_op("ld_merged", 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hA5ADBEEF, 3);
        run_op("st_pattern", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12807F34, 1'b0, 32'h0, 2);
        sb.push_back('{1'b0, 32'hFFFFFF80, 3});
        issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h12, 32'hFFFFFFFF, 1'b0);
        n_chk++; if (m1.mem_en !== 1'b1 || m1.mem_we !== 4'b0) $display("FAIL ldb access got en=%b we=%b want 1/0000", m1.mem_en, m1.mem_we); else n_pass++;
        begin
            bit e, en; logic [31:0] rd; int lat; exp_t x;
            wait_resp(1'b0, e, rd, lat, en);
            x = sb.pop_front();
            n_chk++; if (lat !== x.lat || rd !== x.rdata || e !== x.err) $display("FAIL ldb_s1 got lat=%0d rd=%h want lat=%0d rd=%h", lat, rd, x.lat, x.rdata); else n_pass++;
        end
        run_op("ldb_u1", 1'b0, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, 32'h00000080, 3);
        run_op("ldh_s1", 1'b0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h00007F34, 3);
        run_op("ldh_u16", 1'b0, 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0, 32'h00001234, 3);
    endtask

    task automatic test_loads_lat2();
        run_op("ldb_s2", 1'b1, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFFFF80, 4);
        run_op("ldb_u2", 1'b1, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, 32'h00000080, 4);
        run_op("ldh_s2", 1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'h00001280, 4);
    endtask

    task automatic test_errors();
        run_op("err_half", 1'b0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1);
        run_op("err_size", 1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1);
        run_op("err_word", 1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h55555555, 1'b1, 32'h0, 1);
        run_op("ld_after_err", 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12807F34, 3);
    endtask

    task automatic test_back_to_back();
        bit e, en, rdy_seen; logic [31:0] rd; int lat; exp_t x;
        sb.push_back('{1'b0, 32'h12807F34, 3});
        sb.push_back('{1'b0, 32'h0000007F, 3});
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        // Second request presented immediately; the first op must not see the change.
        drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        rdy_seen = 0; lat = 1;
        while (!m1.resp_valid && lat < 20) begin
            rdy_seen |= m1.req_ready;
            @(posedge clk); #1; lat++;
        end
        rdy_seen |= m1.req_ready;
        x = sb.pop_front();
        n_chk++; if (lat !== x.lat || m1.resp_rdata !== x.rdata) $display("FAIL b2b first got lat=%0d rd=%h want lat=%0d rd=%h", lat, m1.resp_rdata, x.lat, x.rdata); else n_pass++;
        n_chk++; if (rdy_seen !== 1'b0) $display("FAIL b2b req_ready high during first op got 1 want 0"); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (m1.req_ready !== 1'b1 || m1.mem_en !== 1'b0) $display("FAIL b2b after resp got rdy=%b en=%b want 1/0", m1.req_ready, m1.mem_en); else n_pass++;
        @(posedge clk); #1;
        m1.req_valid = 1'b0;
        n_chk++; if (m1.mem_en !== 1'b1 || m1.mem_addr !== 32'h4) $display("FAIL b2b second accept got en=%b addr=%h want 1/4", m1.mem_en, m1.mem_addr); else n_pass++;
        wait_resp(1'b0, e, rd, lat, en);
        x = sb.pop_front();
        n_chk++; if (lat !== x.lat || rd !== x.rdata || e !== x.err) $display("FAIL b2b second got lat=%0d rd=%h want lat=%0d rd=%h", lat, rd, x.lat, x.rdata); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit spur;
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_chk++; if (m1.mem_en !== 1'b0 || m1.mem_we !== 4'b0 || m1.resp_valid !== 1'b0) $display("FAIL rstmid outputs got en=%b we=%b rv=%b want 0", m1.mem_en, m1.mem_we, m1.resp_valid); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        spur = 0;
        for (int i = 0; i < 4; i++) begin
            spur |= m1.resp_valid;
            @(posedge clk); #1;
        end
        n_chk++; if (spur !== 1'b0) $display("FAIL rstmid spurious resp_valid got 1 want 0"); else n_pass++;
        n_chk++; if (m1.req_ready !== 1'b1) $display("FAIL rstmid req_ready got %b want 1", m1.req_ready); else n_pass++;
        run_op("rstmid_ld", 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12807F34, 3);
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_half_store();
        test_loads_lat1();
        test_loads_lat2();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
